// File: rtl/mem_bus_router_if.sv
// rtl/mem_bus_router_if.sv - CPU, block RAM and MMIO signal bundle for mem_bus_router
// master: router view; slave: CPU and memory targets view.
interface mem_bus_router_if;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_byte;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [1:0]  ram_be;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic        mmio_en;
  logic        mmio_we;
  logic        mmio_byte_select;
  logic        mmio_byte_enable;
  logic [15:0] mmio_addr;
  logic [15:0] mmio_wdata;
  logic [15:0] mmio_rdata;
  logic        mmio_serviced_read;
  logic        mmio_wait;

  modport master (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err,
    output ram_en, ram_we, ram_addr, ram_be, ram_wdata,
    input  ram_rdata,
    output mmio_en, mmio_we, mmio_byte_select, mmio_byte_enable, mmio_addr, mmio_wdata,
    input  mmio_rdata, mmio_serviced_read, mmio_wait
  );

  modport slave (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  ram_en, ram_we, ram_addr, ram_be, ram_wdata,
    output ram_rdata,
    input  mmio_en, mmio_we, mmio_byte_select, mmio_byte_enable, mmio_addr, mmio_wdata,
    output mmio_rdata, mmio_serviced_read, mmio_wait
  );
endinterface

// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - routes one CPU load/store to block RAM or MMIO by byte address
// Optional MMIO wait timeout with error reporting: define MEM_TIMEOUT_EN.
module mem_bus_router #(
  parameter logic [15:0] MMIO_BASE = 16'hFF00
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic             clk,
  input logic             rst,
  mem_bus_router_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t state;
  logic   we_q;
  logic   byte_q;
  logic   lane_q;
  logic   mmio_q;
  logic   req_is_mmio;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`endif

  assign req_is_mmio = (bus.cpu_addr >= MMIO_BASE);

  // The MMIO strobe has to react to mmio_wait within the same cycle.
  assign bus.mmio_en = (state == ISSUE) && mmio_q && !bus.mmio_wait;

`ifndef MEM_TIMEOUT_EN
  assign bus.cpu_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      we_q                 <= 1'b0;
      byte_q               <= 1'b0;
      lane_q               <= 1'b0;
      mmio_q               <= 1'b0;
      bus.cpu_rdata        <= 16'h0000;
      bus.cpu_ready        <= 1'b0;
      bus.ram_en           <= 1'b0;
      bus.ram_we           <= 1'b0;
      bus.ram_addr         <= 15'h0000;
      bus.ram_be           <= 2'b00;
      bus.ram_wdata        <= 16'h0000;
      bus.mmio_we          <= 1'b0;
      bus.mmio_byte_select <= 1'b0;
      bus.mmio_byte_enable <= 1'b0;
      bus.mmio_addr        <= 16'h0000;
      bus.mmio_wdata       <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
      bus.cpu_err          <= 1'b0;
      wait_cnt             <= 8'h00;
`endif
    end else begin
      bus.cpu_ready <= 1'b0;
      bus.ram_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            we_q                 <= bus.cpu_we;
            byte_q               <= bus.cpu_byte;
            lane_q               <= bus.cpu_addr[0];
            mmio_q               <= req_is_mmio;
            // Target-side address/data are loaded once and held through DONE.
            bus.ram_en           <= !req_is_mmio;
            bus.ram_we           <= bus.cpu_we && !req_is_mmio;
            bus.ram_addr         <= bus.cpu_addr[15:1];
            bus.ram_be           <= !bus.cpu_byte ? 2'b11 : (bus.cpu_addr[0] ? 2'b10 : 2'b01);
            bus.ram_wdata        <= bus.cpu_byte ? {bus.cpu_wdata[7:0], bus.cpu_wdata[7:0]}
                                                 : bus.cpu_wdata;
            bus.mmio_we          <= bus.cpu_we && req_is_mmio;
            bus.mmio_byte_select <= bus.cpu_addr[0];
            bus.mmio_byte_enable <= bus.cpu_byte;
            bus.mmio_addr        <= {1'b0, bus.cpu_addr[15:1]};
            bus.mmio_wdata       <= bus.cpu_wdata;
`ifdef MEM_TIMEOUT_EN
            wait_cnt             <= 8'h00;
`endif
            state                <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mmio_q || !bus.mmio_wait) begin
            if (we_q) begin
              bus.cpu_ready <= 1'b1;
              state         <= DONE;
            end else begin
              state         <= CAPTURE;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= 16'h0000;
            state         <= DONE;
          end else begin
            wait_cnt      <= wait_cnt + 8'd1;
          end
`endif
        end
        CAPTURE: begin
          if (mmio_q)
            bus.cpu_rdata <= bus.mmio_serviced_read ? bus.mmio_rdata : 16'h0000;
          else if (!byte_q)
            bus.cpu_rdata <= bus.ram_rdata;
          else
            bus.cpu_rdata <= {8'h00, lane_q ? bus.ram_rdata[15:8] : bus.ram_rdata[7:0]};
`ifdef MEM_TIMEOUT_EN
          bus.cpu_err   <= mmio_q && !bus.mmio_serviced_read;
`endif
          bus.cpu_ready <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
`ifdef MEM_TIMEOUT_EN
          bus.cpu_err <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_router.sv
// tb/tb_mem_bus_router.sv - directed self-checking bench for mem_bus_router
// Build with MEM_TIMEOUT_EN defined to also exercise the MMIO wait timeout.
module tb_mem_bus_router;

`ifdef MEM_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_router_if bus();

`ifdef MEM_TIMEOUT_EN
  mem_bus_router #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  mem_bus_router dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // Block RAM model: synchronous read, lane-masked write.
  logic [15:0] mem [0:32767];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        if (bus.ram_be[0]) mem[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
        if (bus.ram_be[1]) mem[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  int          r_lat, r_ram, r_mmio, r_mmio_cyc;
  logic [15:0] r_rdata, r_wd, r_maddr, r_mwd;
  logic [14:0] r_raddr;
  logic [1:0]  r_be;
  logic        r_err, r_rwe, r_mwe, r_bsel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request in the current (IDLE) cycle, holds mmio_wait high for
  // the first 'waits' cycles after it, and records strobes until cpu_ready.
  task automatic access(input logic we, input logic byt, input logic [15:0] addr,
                        input logic [15:0] wdata, input int waits);
    int c;
    c = 0;
    r_lat = -1; r_ram = 0; r_mmio = 0; r_mmio_cyc = -1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_byte = byt;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    bus.mmio_wait = (waits > 0);
    while (c < 40 && r_lat < 0) begin
      @(posedge clk); #1;
      c++;
      bus.mmio_wait = (c <= waits);
      #1;
      if (bus.ram_en) begin
        r_ram++; r_be = bus.ram_be; r_wd = bus.ram_wdata; r_raddr = bus.ram_addr; r_rwe = bus.ram_we;
      end
      if (bus.mmio_en) begin
        r_mmio++; r_mmio_cyc = c; r_maddr = bus.mmio_addr; r_mwd = bus.mmio_wdata;
        r_mwe = bus.mmio_we; r_bsel = bus.mmio_byte_select;
      end
      if (bus.cpu_ready) begin
        r_lat = c; r_rdata = bus.cpu_rdata; r_err = bus.cpu_err;
        bus.cpu_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    bus.mmio_wait = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
    bus.mmio_rdata = 16'h0000; bus.mmio_serviced_read = 1'b0; bus.mmio_wait = 1'b0;

    #3;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    chk("rst_mmio_en", 32'(bus.mmio_en), 0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_cpu_err", 32'(bus.cpu_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: RAM word write then read
    access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
    chk("w16_lat", r_lat, 2);
    chk("w16_ram_en", r_ram, 1);
    chk("w16_mmio_en", r_mmio, 0);
    chk("w16_be", 32'(r_be), 32'h3);
    chk("w16_wdata", 32'(r_wd), 32'hBEEF);
    chk("w16_addr", 32'(r_raddr), 32'h0008);
    chk("w16_we", 32'(r_rwe), 1);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    chk("r16_lat", r_lat, 3);
    chk("r16_ram_en", r_ram, 1);
    chk("r16_rdata", 32'(r_rdata), 32'hBEEF);

    // byte reads of both lanes of the word just written
    access(1'b0, 1'b1, 16'h0011, 16'h0000, 0);
    chk("r8_hi_rdata", 32'(r_rdata), 32'h00BE);
    access(1'b0, 1'b1, 16'h0010, 16'h0000, 0);
    chk("r8_lo_rdata", 32'(r_rdata), 32'h00EF);

    // 2: RAM byte write high lane then byte read
    access(1'b1, 1'b1, 16'h0021, 16'h00A5, 0);
    chk("w8_lat", r_lat, 2);
    chk("w8_be", 32'(r_be), 32'h2);
    chk("w8_wdata", 32'(r_wd), 32'hA5A5);
    access(1'b1, 1'b1, 16'h0030, 16'h7766, 0);
    chk("w8_lo_be", 32'(r_be), 32'h1);
    chk("w8_lo_wdata", 32'(r_wd), 32'h6666);
    access(1'b0, 1'b1, 16'h0021, 16'h0000, 0);
    chk("r8_a5_rdata", 32'(r_rdata), 32'h00A5);

    // 3: MMIO write at base, RAM at FEFF just below the boundary
    access(1'b1, 1'b0, 16'hFF00, 16'h003C, 0);
    chk("mw_lat", r_lat, 2);
    chk("mw_mmio_en", r_mmio, 1);
    chk("mw_ram_en", r_ram, 0);
    chk("mw_addr", 32'(r_maddr), 32'h7F80);
    chk("mw_bsel", 32'(r_bsel), 0);
    chk("mw_wdata", 32'(r_mwd), 32'h003C);
    chk("mw_we", 32'(r_mwe), 1);
    access(1'b1, 1'b0, 16'hFEFF, 16'h1234, 0);
    chk("feff_ram_en", r_ram, 1);
    chk("feff_mmio_en", r_mmio, 0);
    chk("feff_addr", 32'(r_raddr), 32'h7F7F);
    chk("feff_be", 32'(r_be), 32'h3);
    access(1'b0, 1'b0, 16'hFEFE, 16'h0000, 0);
    chk("fefe_rdata", 32'(r_rdata), 32'h1234);

    // 4: MMIO read with five wait cycles
    bus.mmio_rdata = 16'h5A5A; bus.mmio_serviced_read = 1'b1;
    access(1'b0, 1'b0, 16'hFF02, 16'h0000, 5);
    chk("mr_lat", r_lat, 8);
    chk("mr_mmio_en", r_mmio, 1);
    chk("mr_mmio_cyc", r_mmio_cyc, 6);
    chk("mr_ram_en", r_ram, 0);
    chk("mr_rdata", 32'(r_rdata), 32'h5A5A);
    chk("mr_err", 32'(r_err), 0);
    chk("mr_addr", 32'(r_maddr), 32'h7F81);

    // unclaimed MMIO read returns zero
    bus.mmio_rdata = 16'hFFFF; bus.mmio_serviced_read = 1'b0;
    access(1'b0, 1'b0, 16'hFF07, 16'h0000, 0);
    chk("mu_lat", r_lat, 3);
    chk("mu_rdata", 32'(r_rdata), 32'h0000);
    chk("mu_err", 32'(r_err), 32'(TO_EN));
    chk("mu_bsel", 32'(r_bsel), 1);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    chk("pre_rst_rdata", 32'(r_rdata), 32'hBEEF);

    // 5: reset during CAPTURE of a RAM read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0; bus.cpu_addr = 16'h0022;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    chk("arst_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("arst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("arst_ram_addr", 32'(bus.ram_addr), 0);
    chk("arst_ram_be", 32'(bus.ram_be), 0);
    @(posedge clk); #1;
    chk("arst_hold_ready", 32'(bus.cpu_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.cpu_ready), 0);
    access(1'b0, 1'b1, 16'h0021, 16'h0000, 0);
    chk("post_rst_lat", r_lat, 3);
    chk("post_rst_rdata", 32'(r_rdata), 32'h00A5);

`ifdef MEM_TIMEOUT_EN
    // 6: mmio_wait stuck high is abandoned after four wait cycles
    access(1'b0, 1'b0, 16'hFF04, 16'h0000, 1000);
    chk("to_lat", r_lat, 5);
    chk("to_mmio_en", r_mmio, 0);
    chk("to_err", 32'(r_err), 1);
    chk("to_rdata", 32'(r_rdata), 0);
    chk("to_err_clear", 32'(bus.cpu_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
